// File: rtl/timing_recovery.sv
// Receive-side VGA timing recovery: measures line/frame lengths from incoming
// sync/blank, tracks lock against the expected mode and rebuilds pixel coordinates.
module timing_recovery #(
  parameter int H_RESOLUTION = 640,
  parameter int V_RESOLUTION = 480,
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic                            blank_in,
  output logic [$clog2(H_RESOLUTION)-1:0] x,
  output logic [$clog2(V_RESOLUTION)-1:0] y,
  output logic                            active,
  output logic                            frame_start,
  output logic                            locked,
  output logic [$clog2(H_TOTAL):0]        h_meas,
  output logic [$clog2(V_TOTAL):0]        v_meas
);
  localparam int XW = $clog2(H_RESOLUTION);
  localparam int YW = $clog2(V_RESOLUTION);
  localparam int HW = $clog2(H_TOTAL) + 1;
  localparam int VW = $clog2(V_TOTAL) + 1;
  localparam int CW = $clog2(2 * H_TOTAL + 1);
  localparam int RW = $clog2(H_TOTAL + 1);
  localparam int LW = $clog2(V_RESOLUTION + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [2:0]    s1_q, s1_d, s2_q, s2_d;   // {hsync, vsync, blank}
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d, v_eff;
  logic [HW-1:0] h_meas_q, h_meas_d;
  logic [VW-1:0] v_meas_q, v_meas_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [LW-1:0] line_idx_q, line_idx_d, line_base;
  logic [RW-1:0] run_q, run_d;
  logic [GW-1:0] good_q, good_d;
  logic          active_q, active_d, frame_start_q, frame_start_d;
  logic          seen_q, seen_d, line_err_q, line_err_d;
  logic          hs_rise, vs_rise, bl_rise, bl_fall, wd, err_now, frame_good;

  assign hs_rise = s1_q[2] & ~s2_q[2];
  assign vs_rise = s1_q[1] & ~s2_q[1];
  assign bl_rise = s1_q[0] & ~s2_q[0];
  assign bl_fall = ~s1_q[0] & s2_q[0];
  assign wd      = (h_cnt_q == CW'(2 * H_TOTAL));

  // A coincident hsync rise belongs to the frame that the vsync rise closes.
  assign v_eff   = (hs_rise && (v_cnt_q != '1)) ? v_cnt_q + VW'(1) : v_cnt_q;
  assign err_now = seen_q & ((hs_rise & (h_cnt_q != CW'(H_TOTAL - 1))) |
                             (bl_rise & active_q & (run_q != RW'(H_RESOLUTION))));
  assign frame_good = (v_eff == VW'(V_TOTAL)) && !(line_err_q || err_now) &&
                      (line_idx_q == LW'(V_RESOLUTION));

  always_comb begin
    s1_d          = s1_q;
    s2_d          = s2_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_meas_d      = h_meas_q;
    v_meas_d      = v_meas_q;
    x_d           = x_q;
    y_d           = y_q;
    line_idx_d    = line_idx_q;
    line_base     = line_idx_q;
    run_d         = run_q;
    active_d      = active_q;
    frame_start_d = frame_start_q;
    if (enable) begin
      s1_d          = {hsync_in, vsync_in, blank_in};
      s2_d          = s1_q;
      frame_start_d = vs_rise;
      if (hs_rise) begin
        h_meas_d = HW'(h_cnt_q) + HW'(1);
        h_cnt_d  = '0;
      end else if (!wd) begin
        h_cnt_d = h_cnt_q + CW'(1);
      end
      v_cnt_d = v_eff;
      if (vs_rise) begin
        v_meas_d  = v_eff;
        v_cnt_d   = '0;
        line_base = '0;
      end
      line_idx_d = line_base;
      // line_idx counts up to V_RESOLUTION so a full frame is recognisable; y clamps one below.
      if (bl_fall) begin
        active_d = 1'b1;
        x_d      = '0;
        run_d    = RW'(1);
        y_d      = (line_base >= LW'(V_RESOLUTION - 1)) ? YW'(V_RESOLUTION - 1) : YW'(line_base);
        if (line_base != LW'(V_RESOLUTION)) line_idx_d = line_base + LW'(1);
      end else if (bl_rise) begin
        active_d = 1'b0;
      end else if (active_q) begin
        if (x_q != XW'(H_RESOLUTION - 1)) x_d = x_q + XW'(1);
        if (run_q != RW'(H_TOTAL)) run_d = run_q + RW'(1);
      end
      if (wd) active_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    seen_d     = seen_q;
    line_err_d = line_err_q;
    if (enable) begin
      if (state_q != SEARCH) begin
        if (hs_rise) seen_d = 1'b1;
        line_err_d = line_err_q | err_now;
      end
      if (vs_rise) begin
        line_err_d = 1'b0;
        unique case (state_q)
          SEARCH: begin
            state_d = ACQUIRE;
            good_d  = '0;
          end
          ACQUIRE: begin
            if (frame_good) begin
              good_d = good_q + GW'(1);
              if (good_q + GW'(1) == GW'(LOCK_FRAMES)) state_d = LOCKED;
            end else begin
              good_d = '0;
            end
          end
          LOCKED: begin
            if (!frame_good) begin
              state_d = ACQUIRE;
              good_d  = '0;
            end
          end
          default: state_d = SEARCH;
        endcase
      end
      if (wd) begin
        state_d    = SEARCH;
        good_d     = '0;
        seen_d     = 1'b0;
        line_err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEARCH;
      s1_q          <= '0;
      s2_q          <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_meas_q      <= '0;
      v_meas_q      <= '0;
      x_q           <= '0;
      y_q           <= '0;
      line_idx_q    <= '0;
      run_q         <= '0;
      good_q        <= '0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      seen_q        <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_idx_q    <= line_idx_d;
      run_q         <= run_d;
      good_q        <= good_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      seen_q        <= seen_d;
      line_err_q    <= line_err_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == LOCKED);
  assign h_meas      = h_meas_q;
  assign v_meas      = v_meas_q;

endmodule
